resp_misr19: RTL



---
 rtl/resp_misr19.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/resp_misr19.sv
// ----------------------------------------------------------------------------
// resp_misr19 -- multiple-input signature register for response compaction.
//
// Absorbs the 19-bit primary-output vector of the core under test on every
// valid cycle of a run, using a Galois shift-left MISR. After CAPTURE_CNT
// absorbs it compares the signature against GOLDEN and reports PASS with a
// level DONE, which is held until the next accepted START or reset.
//
// Ports:
//   CK          in   clock, rising edge
//   RST_N       in   synchronous active-low reset
//   START       in   begin a run (only sampled in IDLE)
//   CAPTURE_CNT in   number of vectors to absorb, latched on START
//   RESP        in   response vector from the core
//   RESP_MASK   in   per-bit absorb mask (only with RESP_XMASK_EN)
//   RESP_VALID  in   absorb RESP this cycle (RUN only)
//   GOLDEN      in   expected final signature, sampled in CHECK
//   SIG         out  current signature
//   BUSY        out  high in RUN and CHECK
//   DONE        out  result valid (level)
//   PASS        out  SIG matched GOLDEN, valid while DONE=1
//
// Optional feature macro: RESP_XMASK_EN (adds RESP_MASK; masked bits absorb 0).
// ----------------------------------------------------------------------------
module resp_misr19 #(
   parameter int unsigned WIDTH = 19,
   parameter logic [WIDTH-1:0] POLY = 19'h00027,
   parameter logic [WIDTH-1:0] SEED = 19'h00000,
   parameter int unsigned CNT_W = 16
) (
   input  logic             CK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [CNT_W-1:0] CAPTURE_CNT,
   input  logic [WIDTH-1:0] RESP,
`ifdef RESP_XMASK_EN
   input  logic [WIDTH-1:0] RESP_MASK,
`endif
   input  logic             RESP_VALID,
   input  logic [WIDTH-1:0] GOLDEN,
   output logic [WIDTH-1:0] SIG,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_sig;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;

   logic [WIDTH-1:0]  w_sig_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;
   logic              w_pass_nxt;
   logic [WIDTH-1:0]  w_resp_abs;

   // One Galois shift-left step: shift, fold the outgoing MSB back through
   // the tap mask, then XOR in the response vector.
   function automatic logic [WIDTH-1:0] misr_step(
      input logic [WIDTH-1:0] sig,
      input logic [WIDTH-1:0] resp
   );
      logic [WIDTH-1:0] shifted;
      shifted = {sig[WIDTH-2:0], 1'b0};
      if (sig[WIDTH-1]) begin
         shifted = shifted ^ POLY;
      end else begin
         shifted = shifted;
      end
      return shifted ^ resp;
   endfunction

`ifdef RESP_XMASK_EN
   // Masked bits contribute zero so unknowns from uninitialised core flops
   // never reach the signature.
   assign w_resp_abs = RESP & ~RESP_MASK;
`else
   assign w_resp_abs = RESP;
`endif

   // State register; reset wins over every other input and aborts any run.
   always_ff @(posedge CK) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_state_nxt = (CAPTURE_CNT != '0) ? ST_RUN : ST_CHECK;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Leaving on the absorb that consumes the last count.
            if (RESP_VALID && (r_cnt == CNT_ONE)) begin
               w_state_nxt = ST_CHECK;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_CHECK: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Next values of the datapath and the registered status outputs.
   always_comb begin
      w_sig_nxt  = r_sig;
      w_cnt_nxt  = r_cnt;
      w_done_nxt = r_done;
      w_pass_nxt = r_pass;
      w_busy_nxt = (w_state_nxt != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            // START beats RESP_VALID here: no absorb on the accept cycle.
            if (START) begin
               w_sig_nxt  = SEED;
               w_cnt_nxt  = CAPTURE_CNT;
               w_done_nxt = 1'b0;
               w_pass_nxt = 1'b0;
            end else begin
               w_sig_nxt  = r_sig;
            end
         end
         ST_RUN: begin
            if (RESP_VALID) begin
               w_sig_nxt = misr_step(r_sig, w_resp_abs);
               w_cnt_nxt = r_cnt - CNT_ONE;
            end else begin
               w_sig_nxt = r_sig;
            end
         end
         ST_CHECK: begin
            w_done_nxt = 1'b1;
            w_pass_nxt = (r_sig == GOLDEN);
         end
         default: begin
            w_sig_nxt = r_sig;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge CK) begin
      if (!RST_N) begin
         r_sig  <= SEED;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else begin
         r_sig  <= w_sig_nxt;
         r_cnt  <= w_cnt_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_pass <= w_pass_nxt;
      end
   end

   assign SIG  = r_sig;
   assign BUSY = r_busy;
   assign DONE = r_done;
   assign PASS = r_pass;

endmodule
